seq_shift_add_multiplier: RTL and testbench

//   Iterative radix-2 shift-add unsigned multiplier for the mantissa datapath.

---
 rtl/seq_shift_add_multiplier.sv | 99 +++++++++
 tb/tb_seq_shift_add_multiplier.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product, one adder reused per bit.
// Latency: WIDTH+1 cycles from accepted start to the end of the one-cycle done pulse.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [CW-1:0]    counter;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mq_nxt;
    logic             last_iter;
    logic             accept;

    // Carry lands in the accumulator MSB, the dropped sum LSB moves into the multiplier register.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, (mq[0] ? mcand : {WIDTH{1'b0}})};
        acc_nxt   = sum[WIDTH:1];
        mq_nxt    = {sum[0], mq[WIDTH-1:1]};
        last_iter = (counter == CW'(WIDTH - 1));
        accept    = (state != RUN) && start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            counter <= '0;
            product <= '0;
            zero    <= 1'b1;
        end else if (accept) begin
            mcand   <= a;
            mq      <= b;
            acc     <= '0;
            counter <= '0;
        end else if (state == RUN) begin
            acc     <= acc_nxt;
            mq      <= mq_nxt;
            counter <= counter + 1'b1;
            if (last_iter) begin
                product <= {acc_nxt, mq_nxt};
                zero    <= ({acc_nxt, mq_nxt} == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: directed scenarios plus random traffic checked every cycle
// against a countdown/arithmetic reference model.
module tb_seq_shift_add_multiplier;

    localparam int W = 11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;
    logic             zero;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    int               m_rem = 0;
    longint unsigned  m_prod = 0;
    longint unsigned  m_pend = 0;
    int               done_cnt = 0;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs held across the edge, then compare.
    task automatic step();
        @(negedge clk);
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rem  = 0;
            m_prod = 0;
        end else if (m_busy) begin
            m_rem--;
            m_done = 1'b0;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_prod = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_busy = 1'b1;
                m_rem  = W;
                m_pend = longint'(a) * longint'(b);
            end
        end
        if (m_done) done_cnt++;
        check_val("busy", busy, m_busy);
        check_val("done", done, m_done);
        check_val("product", product, m_prod);
        check_val("zero", zero, (m_prod == 0));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input int av, input int bv);
        start = 1'b1;
        a = W'(av);
        b = W'(bv);
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!m_done && n < bound) begin
            step();
            n++;
        end
        check_val("done_within_bound", m_done, 1);
    endtask

    initial begin
        int c0;
        // 1: reset state
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(3);

        // 2: max operands, exact latency
        issue(2047, 2047);
        steps(W - 1);
        check_val("max_not_done_early", done, 0);
        step();
        check_val("max_done_at_N_plus_W", done, 1);
        check_val("max_product", product, 22'h3FF001);
        step();
        check_val("max_done_one_cycle", done, 0);

        // 3: zero operand
        issue(0, 1234);
        wait_done(W + 2);
        check_val("zero_product", product, 0);
        check_val("zero_flag", zero, 1);
        step();
        check_val("zero_done_pulse_len", done, 0);

        // 4: start during RUN is ignored
        c0 = done_cnt;
        issue(3, 5);
        steps(3);
        start = 1'b1; a = 7; b = 7;
        step();
        start = 1'b0;
        steps(W + 6);
        check_val("ignored_start_single_done", done_cnt - c0, 1);
        check_val("ignored_start_product", product, 15);

        // 5: back-to-back start in DONE cycle
        issue(100, 200);
        wait_done(W + 2);
        check_val("b2b_first", product, 20000);
        start = 1'b1; a = 5; b = 6;
        step();
        start = 1'b0;
        check_val("b2b_busy", busy, 1);
        wait_done(W + 2);
        check_val("b2b_second", product, 30);

        // 6: reset aborts RUN
        c0 = done_cnt;
        issue(1000, 1000);
        steps(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        steps(W + 3);
        check_val("abort_no_done", done_cnt - c0, 0);
        check_val("abort_product", product, 0);
        issue(9, 9);
        wait_done(W + 2);
        check_val("after_abort", product, 81);
        steps(2);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int sel;
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 7);
            a = (sel == 0) ? W'(0) : (sel == 1) ? {W{1'b1}} : W'($urandom);
            sel = $urandom_range(0, 7);
            b = (sel == 0) ? W'(0) : (sel == 1) ? {W{1'b1}} : W'($urandom);
            step();
        end
        reset = 1'b0;
        start = 1'b0;
        steps(W + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
